// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam int DATA_W  = 32;
    localparam int TMO_W   = 8;
    localparam int BURST_W = 4;

    localparam logic [31:0] MEM_LO_DEF = 32'h0000_0000;
    localparam logic [31:0] MEM_HI_DEF = 32'h0000_FFFF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and memory bus signals seen by the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    import mem_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              if_done;
    logic [DATA_W-1:0] instr;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              wait_instr;
    logic              wait_data;
    logic              instr_segv;
    logic              data_segv;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, if_done, instr, d_done, d_rdata,
               wait_instr, wait_data, instr_segv, data_segv
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, if_done, instr, d_done, d_rdata,
               wait_instr, wait_data, instr_segv, data_segv
    );

endinterface

// File: rtl/mem_port_arbiter_addr_checker.sv
// Combinational range and word-alignment check on a byte address.
module addr_checker #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    output logic              legal
);

    assign legal = (addr >= lo) && (addr <= hi) && (addr[1:0] == 2'b00);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, data first with a
// starvation guard for fetch, plus bounds/alignment faults and bus timeout.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] MEM_LO   = ADDR_W'(MEM_LO_DEF),
    parameter logic [ADDR_W-1:0] MEM_HI   = ADDR_W'(MEM_HI_DEF),
    parameter int              TIMEOUT    = 16,
    parameter int              MAX_DBURST = 4
) (
    input logic             clk,
    input logic             reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_BUSY_I = BUSY_I;
    localparam logic [1:0] ST_BUSY_D = BUSY_D;
    localparam logic [1:0] ST_RESP   = RESP;

    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DBURST);

    logic [1:0]         state;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [BURST_W-1:0] burst_cnt;

    logic              sel_data;
    logic              sel_instr;
    logic [ADDR_W-1:0] sel_addr;
    logic              legal;

    // The guard only matters while a fetch is actually waiting.
    assign sel_data  = bus.d_req && (!bus.if_req || (burst_cnt < BURST_MAX));
    assign sel_instr = !sel_data && bus.if_req;
    assign sel_addr  = sel_data ? bus.d_addr : bus.if_addr;

    addr_checker #(.ADDR_W(ADDR_W)) u_addr_checker (
        .addr  (sel_addr),
        .lo    (MEM_LO),
        .hi    (MEM_HI),
        .legal (legal)
    );

    assign bus.wait_instr = bus.if_req & ~bus.if_done;
    assign bus.wait_data  = bus.d_req & ~bus.d_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            tmo_cnt        <= '0;
            burst_cnt      <= '0;
            bus.mem_req    <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.if_done    <= 1'b0;
            bus.d_done     <= 1'b0;
            bus.instr      <= '0;
            bus.d_rdata    <= '0;
            bus.instr_segv <= 1'b0;
            bus.data_segv  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_data || sel_instr) begin
                        if (sel_data && bus.if_req) begin
                            if (burst_cnt != BURST_MAX)
                                burst_cnt <= burst_cnt + 1'b1;
                        end else begin
                            burst_cnt <= '0;
                        end

                        if (!legal) begin
                            state <= ST_RESP;
                            if (sel_data) begin
                                bus.d_done    <= 1'b1;
                                bus.data_segv <= 1'b1;
                                bus.d_rdata   <= '0;
                            end else begin
                                bus.if_done    <= 1'b1;
                                bus.instr_segv <= 1'b1;
                                bus.instr      <= '0;
                            end
                        end else begin
                            state         <= sel_data ? ST_BUSY_D : ST_BUSY_I;
                            tmo_cnt       <= '0;
                            bus.mem_req   <= 1'b1;
                            bus.mem_addr  <= sel_addr;
                            bus.mem_we    <= sel_data & bus.d_we;
                            bus.mem_wdata <= sel_data ? bus.d_wdata : '0;
                        end
                    end
                end

                ST_BUSY_I, ST_BUSY_D: begin
                    if (bus.mem_ack || (tmo_cnt == TMO_LAST)) begin
                        state       <= ST_RESP;
                        tmo_cnt     <= '0;
                        bus.mem_req <= 1'b0;
                        if (state == ST_BUSY_I) begin
                            bus.if_done    <= 1'b1;
                            bus.instr_segv <= !bus.mem_ack;
                            bus.instr      <= bus.mem_ack ? bus.mem_rdata : '0;
                        end else begin
                            bus.d_done    <= 1'b1;
                            bus.data_segv <= !bus.mem_ack;
                            bus.d_rdata   <= (bus.mem_ack && !bus.mem_we) ? bus.mem_rdata : '0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    state          <= ST_IDLE;
                    bus.if_done    <= 1'b0;
                    bus.d_done     <= 1'b0;
                    bus.instr_segv <= 1'b0;
                    bus.data_segv  <= 1'b0;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch/load/store paths, priority,
// burst guard, faults, timeout and reset mid-transaction.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ack_en = 1'b1;
    logic [31:0] rdata_val = 32'h0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    assign bus.mem_ack   = bus.mem_req & ack_en;
    assign bus.mem_rdata = rdata_val;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .MEM_LO     (32'h0000_0000),
        .MEM_HI     (32'h0000_FFFF),
        .TIMEOUT    (16),
        .MAX_DBURST (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete request with an immediately acking memory, starting and
    // ending at a falling edge with the arbiter idle.
    task automatic xfer(input string tag, input bit is_d, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input bit legal);
        rdata_val = rdata;
        ack_en    = 1'b1;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        #1;
        chk({tag, "_wait0"}, 32'(is_d ? bus.wait_data : bus.wait_instr), 32'd1);
        chk({tag, "_req0"}, 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        if (legal) begin
            chk({tag, "_req1"}, 32'(bus.mem_req), 32'd1);
            chk({tag, "_addr"}, bus.mem_addr, addr);
            chk({tag, "_we"}, 32'(bus.mem_we), 32'(is_d & we));
            if (is_d && we) chk({tag, "_wdata"}, bus.mem_wdata, wdata);
            chk({tag, "_wait1"}, 32'(is_d ? bus.wait_data : bus.wait_instr), 32'd1);
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(is_d ? bus.d_done : bus.if_done), 32'd1);
        chk({tag, "_segv"}, 32'(is_d ? bus.data_segv : bus.instr_segv), 32'(!legal));
        chk({tag, "_rdata"}, is_d ? bus.d_rdata : bus.instr,
            (legal && !(is_d && we)) ? rdata : 32'h0);
        chk({tag, "_req_off"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_wait_done"}, 32'(is_d ? bus.wait_data : bus.wait_instr), 32'd0);
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
        @(negedge clk);
        chk({tag, "_done_off"}, 32'(is_d ? bus.d_done : bus.if_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_d;
        int gcnt;
        int hi_cnt;
        int done_at;

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req  = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_dones", 32'({bus.if_done, bus.d_done, bus.instr_segv, bus.data_segv}), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        xfer("fetch100", 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b1);

        // Simultaneous fetch and load: load served first, fetch keeps waiting.
        rdata_val = 32'h1234_5678;
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
        @(negedge clk);
        chk("both_addr_d", bus.mem_addr, 32'h200);
        chk("both_wait_i1", 32'(bus.wait_instr), 32'd1);
        @(negedge clk);
        chk("both_d_done", 32'(bus.d_done), 32'd1);
        chk("both_d_rdata", bus.d_rdata, 32'h1234_5678);
        chk("both_wait_i2", 32'(bus.wait_instr), 32'd1);
        bus.d_req = 1'b0;
        rdata_val = 32'h8765_4321;
        @(negedge clk);
        chk("both_wait_i3", 32'(bus.wait_instr), 32'd1);
        @(negedge clk);
        chk("both_req_i", 32'(bus.mem_req), 32'd1);
        chk("both_addr_i", bus.mem_addr, 32'h300);
        @(negedge clk);
        chk("both_if_done", 32'(bus.if_done), 32'd1);
        chk("both_instr", bus.instr, 32'h8765_4321);
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);

        // Burst guard: both held, expect D,D,D,D,I,D,D,D,D,I (bit i = data).
        exp_d = 10'b01_1110_1111;
        gcnt = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h400;
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        for (int c = 0; c < 200 && gcnt < 10; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                chk($sformatf("grant%0d", gcnt), 32'(bus.mem_addr == 32'h400), 32'(exp_d[gcnt]));
                gcnt++;
            end
        end
        chk("grant_cnt", 32'(gcnt), 32'd10);
        bus.d_req = 1'b0; bus.if_req = 1'b0;
        repeat (3) @(negedge clk);

        xfer("ld_10002", 1'b1, 1'b0, 32'h1_0002, 32'h0, 32'h5555_AAAA, 1'b0);
        xfer("ld_fffc", 1'b1, 1'b0, 32'h0000_FFFC, 32'h0, 32'h1122_3344, 1'b1);
        xfer("ld_10000", 1'b1, 1'b0, 32'h1_0000, 32'h0, 32'h0BAD_0BAD, 1'b0);
        xfer("if_102", 1'b0, 1'b0, 32'h102, 32'h0, 32'h7777_7777, 1'b0);
        xfer("st_0", 1'b1, 1'b1, 32'h0, 32'hA5A5_A5A5, 32'h9999_9999, 1'b1);

        // Store to a memory that never acks.
        ack_en = 1'b0;
        hi_cnt = 0;
        done_at = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hCAFE_F00D;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                hi_cnt++;
                if (hi_cnt == 1) begin
                    chk("tmo_we", 32'(bus.mem_we), 32'd1);
                    chk("tmo_wdata", bus.mem_wdata, 32'hCAFE_F00D);
                end
            end
            if (bus.d_done) begin
                done_at = c;
                chk("tmo_segv", 32'(bus.data_segv), 32'd1);
                break;
            end
        end
        chk("tmo_req_cycles", 32'(hi_cnt), 32'd16);
        chk("tmo_done_cycle", 32'(done_at), 32'd17);
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("tmo_done_off", 32'(bus.d_done), 32'd0);

        // Reset while a load is outstanding.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
        @(negedge clk);
        chk("rbusy_req", 32'(bus.mem_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("rbusy_req_drop", 32'(bus.mem_req), 32'd0);
        bus.d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
        xfer("fetch104", 1'b0, 1'b0, 32'h104, 32'h0, 32'h0BAD_F00D, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
